gpr_file_mp: RTL

- Parametrised multi-port general-purpose register file for the NPC core, replacing the fixed 2-read/1-write regfile.
- Adds configurable read/write port counts, deterministic write-port priority and a per-register pending-write scoreboard for issue-stage hazard detection.
- Adds a sequential post-reset clear sweep, so register contents are defined without relying on simulator initialisation.
- Sits between decode/issue (read ports, scoreboard set) and writeback (write ports).

---
 rtl/gpr_pkg.sv | 8 +
 rtl/gpr_scoreboard.sv | 37 +++
 rtl/gpr_file_mp.sv | 76 +++++++
 3 files changed

// File: rtl/gpr_pkg.sv
// gpr_pkg: shared defaults, zero-register index, sweep FSM states and zero word for the GPR file
package gpr_pkg;
  localparam int XLEN_DEFAULT = 64;
  localparam int NREGS_DEFAULT = 32;
  localparam int ZERO_REG = 0;
  localparam logic [XLEN_DEFAULT-1:0] ZERO_WORD = '0;
  typedef enum logic {INIT, RUN} gpr_state_t;
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register pending-write bits (set beats clear, x0 never pending) and per-read-port busy lookup
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD = 2,
  parameter int NWR = 1,
  parameter int AW = $clog2(NREGS)
)(
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic [NWR-1:0] wc,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic sb_set_en,
  input  logic [AW-1:0] sb_set_addr,
  input  logic [NRD-1:0] rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NRD-1:0] hit,
  output logic [NRD-1:0] rd_busy
);
  logic [NREGS-1:0] pending, pending_n;
  always_comb begin
    pending_n = pending;
    for (int i = 0; i < NWR; i++)
      if (wc[i]) pending_n[wr_addr[i*AW +: AW]] = 1'b0;
    if (run && sb_set_en) pending_n[sb_set_addr] = 1'b1;
    pending_n[ZERO_REG] = 1'b0;
  end
  always_ff @(posedge clk)
    pending <= rst ? '0 : pending_n;
  always_comb begin
    rd_busy = '0;
    for (int j = 0; j < NRD; j++)
      rd_busy[j] = run & rd_en[j] & pending[rd_addr[j*AW +: AW]] & ~hit[j];
  end
endmodule

// File: rtl/gpr_file_mp.sv
// gpr_file_mp: multi-port GPR file (clk, rst, wr_en/wr_addr/wr_data, rd_en/rd_addr -> rd_data/rd_busy, sb_set_en/sb_set_addr, init_done) with post-reset clear sweep; GPR_BYPASS_EN enables same-cycle write-to-read bypass
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD = 2,
  parameter int NWR = 1,
  localparam int AW = $clog2(NREGS)
)(
  input  logic clk,
  input  logic rst,
  input  logic [NWR-1:0] wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD-1:0] rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0] rd_busy,
  input  logic sb_set_en,
  input  logic [AW-1:0] sb_set_addr,
  output logic init_done
);
  gpr_state_t state, state_n;
  logic [AW-1:0] cnt;
  logic [XLEN-1:0] regs [NREGS];
  logic run;
  logic [NWR-1:0] wc;
  logic [NRD-1:0] hit;
  assign run = state == RUN;
  assign init_done = run;
  assign state_n = (state == INIT && cnt == AW'(NREGS - 1)) ? RUN : state;
  always_comb begin
    wc = '0;
    for (int i = 0; i < NWR; i++)
      wc[i] = run & wr_en[i] & (wr_addr[i*AW +: AW] != AW'(ZERO_REG));
  end
  always_ff @(posedge clk) begin
    state <= rst ? INIT : state_n;
    cnt <= rst ? '0 : run ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      if (!run) regs[cnt] <= XLEN'(ZERO_WORD);
      for (int i = 0; i < NWR; i++)
        if (wc[i]) regs[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
    end
  always_comb begin
    rd_data = '0;
    hit = '0;
    for (int j = 0; j < NRD; j++)
      if (run && rd_en[j] && rd_addr[j*AW +: AW] != AW'(ZERO_REG)) begin
        rd_data[j*XLEN +: XLEN] = regs[rd_addr[j*AW +: AW]];
`ifdef GPR_BYPASS_EN
        for (int i = 0; i < NWR; i++)
          if (wc[i] && wr_addr[i*AW +: AW] == rd_addr[j*AW +: AW]) begin
            rd_data[j*XLEN +: XLEN] = wr_data[i*XLEN +: XLEN];
            hit[j] = 1'b1;
          end
`endif
      end
  end
  gpr_scoreboard #(.NREGS(NREGS), .NRD(NRD), .NWR(NWR), .AW(AW)) u_sb (
    .clk(clk),
    .rst(rst),
    .run(run),
    .wc(wc),
    .wr_addr(wr_addr),
    .sb_set_en(sb_set_en),
    .sb_set_addr(sb_set_addr),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .hit(hit),
    .rd_busy(rd_busy)
  );
endmodule
